// File: rtl/conv_addr_pkg.sv
// Shared types, default geometry and elaboration helpers for the convolution window address generator.
package conv_addr_pkg;

  // MNIST conv1 defaults: 28x28 image, 5x5 kernel, unit stride, 4 lanes.
  localparam int unsigned DEF_IMG_W  = 28;
  localparam int unsigned DEF_IMG_H  = 28;
  localparam int unsigned DEF_K      = 5;
  localparam int unsigned DEF_STRIDE = 1;
  localparam int unsigned DEF_LANES  = 4;
  localparam int unsigned DEF_ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of window positions along one image dimension.
  function automatic int unsigned out_dim(input int unsigned img, input int unsigned k,
                                          input int unsigned stride);
    return (img - k) / stride + 1;
  endfunction

  // First pixel address of the row band owned by lane l.
  function automatic int unsigned lane_base(input int unsigned l, input int unsigned rpl,
                                            input int unsigned stride, input int unsigned img_w);
    return l * rpl * stride * img_w;
  endfunction

  // Bits needed to hold a count in [0, max]; never less than one.
  function automatic int unsigned cnt_w(input int unsigned max);
    return (max < 2) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter; wrap flags the increment that returns it to zero so counters can be chained.
module wrap_counter
  import conv_addr_pkg::*;
#(
  parameter int unsigned MAX = 1,
  parameter int unsigned W   = cnt_w(MAX)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  assign wrap = inc && (count == MAX_V);

  // Count register: clear wins over increment.
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/conv_window_addr_gen.sv
// Walks a KxK window over an IMG_W x IMG_H image, emitting one address per lane per beat.
module conv_window_addr_gen
  import conv_addr_pkg::*;
#(
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H,
  parameter int unsigned K      = DEF_K,
  parameter int unsigned STRIDE = DEF_STRIDE,
  parameter int unsigned LANES  = DEF_LANES,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    ready,
  output logic                    valid,
  output logic [LANES*ADDR_W-1:0] addr,
  output logic                    win_first,
  output logic                    win_last,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned OUT_W = out_dim(IMG_W, K, STRIDE);
  localparam int unsigned OUT_H = out_dim(IMG_H, K, STRIDE);
  localparam int unsigned RPL   = OUT_H / LANES;
  localparam int unsigned KW    = cnt_w(K - 1);
  localparam int unsigned OCW   = cnt_w(OUT_W - 1);
  localparam int unsigned ORW   = cnt_w(RPL - 1);

  // Reject geometries the window walk cannot tile exactly.
  if (K > IMG_W || K > IMG_H || STRIDE == 0 || LANES == 0) begin : g_bad_dims
    $error("conv_window_addr_gen: kernel larger than image or zero stride/lanes");
  end
  if ((IMG_W - K) % STRIDE != 0 || (IMG_H - K) % STRIDE != 0 || OUT_H % LANES != 0)
  begin : g_bad_tiling
    $error("conv_window_addr_gen: stride or lane count does not tile the image");
  end
  if (64'(IMG_W) * 64'(IMG_H) > (64'd1 << ADDR_W)) begin : g_bad_addr_w
    $error("conv_window_addr_gen: ADDR_W too narrow for the image");
  end

  state_e state_q, state_d;

  logic           accept;
  logic           clr;
  logic           kc_wrap, kr_wrap, oc_wrap, last_beat;
  logic [KW-1:0]  kc, kr;
  logic [OCW-1:0] oc;
  logic [ORW-1:0] orow;

  // A beat is consumed only while presenting; start re-arms from IDLE or DONE only.
  assign accept = (state_q == RUN) && ready;
  assign clr    = start && (state_q != RUN);

  wrap_counter #(.MAX(K - 1), .W(KW)) u_kc (
    .clk(clk), .reset_n(reset_n), .inc(accept), .clr(clr), .count(kc), .wrap(kc_wrap)
  );
  wrap_counter #(.MAX(K - 1), .W(KW)) u_kr (
    .clk(clk), .reset_n(reset_n), .inc(kc_wrap), .clr(clr), .count(kr), .wrap(kr_wrap)
  );
  wrap_counter #(.MAX(OUT_W - 1), .W(OCW)) u_oc (
    .clk(clk), .reset_n(reset_n), .inc(kr_wrap), .clr(clr), .count(oc), .wrap(oc_wrap)
  );
  wrap_counter #(.MAX(RPL - 1), .W(ORW)) u_orow (
    .clk(clk), .reset_n(reset_n), .inc(oc_wrap), .clr(clr), .count(orow), .wrap(last_beat)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_beat) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Status flags registered from the next state so they track state_q exactly.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      valid <= (state_d == RUN);
      busy  <= (state_d == RUN);
      done  <= (state_d == DONE);
    end
  end

  assign win_first = valid && (kc == '0) && (kr == '0);
  assign win_last  = valid && (kc == KW'(K - 1)) && (kr == KW'(K - 1));

  // Per-lane address: band base plus window origin plus tap offset; zero when not presenting.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam int unsigned BASE = lane_base(l, RPL, STRIDE, IMG_W);
    assign addr[l*ADDR_W +: ADDR_W] = valid
      ? ADDR_W'(BASE + (32'(orow) * STRIDE + 32'(kr)) * IMG_W + 32'(oc) * STRIDE + 32'(kc))
      : '0;
  end

endmodule

// File: tb/tb_conv_window_addr_gen.sv
`timescale 1ns/1ps
// Scoreboard bench: default 28x28/5x5/4-lane instance plus a 12x12/3x3/stride-3/2-lane instance.
module tb_conv_window_addr_gen;

  typedef struct {
    logic [63:0] a;
    logic        f;
    logic        l;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        start_a, ready_a, start_b, ready_b;
  logic        valid_a, wf_a, wl_a, busy_a, done_a;
  logic [39:0] addr_a;
  logic        valid_b, wf_b, wl_b, busy_b, done_b;
  logic [15:0] addr_b;

  exp_t        q_a[$];
  exp_t        q_b[$];
  exp_t        e_a, e_b;
  int unsigned beat_a, beat_b;
  int unsigned n_checks, n_fail;
  logic        held_a, exp_done_a, exp_done_b;
  logic [63:0] held_val;

  conv_window_addr_gen u_dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .ready(ready_a), .valid(valid_a),
    .addr(addr_a), .win_first(wf_a), .win_last(wl_a), .busy(busy_a), .done(done_a)
  );

  conv_window_addr_gen #(
    .IMG_W(12), .IMG_H(12), .K(3), .STRIDE(3), .LANES(2), .ADDR_W(8)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .ready(ready_b), .valid(valid_b),
    .addr(addr_b), .win_first(wf_b), .win_last(wl_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected beat stream in window-walk order.
  task automatic push_pass(input int unsigned img_w, input int unsigned k, input int unsigned s,
                           input int unsigned lanes, input int unsigned rpl,
                           input int unsigned out_w, input int unsigned aw, input bit to_b);
    exp_t        e;
    logic [63:0] v;
    int unsigned ad;
    for (int unsigned r = 0; r < rpl; r++)
      for (int unsigned oc = 0; oc < out_w; oc++)
        for (int unsigned kr = 0; kr < k; kr++)
          for (int unsigned kc = 0; kc < k; kc++) begin
            v = '0;
            for (int unsigned l = 0; l < lanes; l++) begin
              ad = l * rpl * s * img_w + (r * s + kr) * img_w + oc * s + kc;
              v  = v | (64'(ad) << (l * aw));
            end
            e.a = v;
            e.f = (kc == 0) && (kr == 0);
            e.l = (kc == k - 1) && (kr == k - 1);
            if (to_b) q_b.push_back(e);
            else      q_a.push_back(e);
          end
  endtask

  // Monitor for instance A: scoreboard pops, directed points, hold stability, done timing.
  always @(negedge clk) begin
    if (!reset_n) begin
      held_a     = 1'b0;
      exp_done_a = 1'b0;
    end else begin
      if (exp_done_a) begin
        chk("done_after_last_a", 64'({done_a, valid_a}), 64'd2);
        exp_done_a = 1'b0;
      end
      if (held_a && valid_a)
        chk("hold_stable_a", {22'b0, wf_a, wl_a, addr_a}, held_val);
      if (valid_a && ready_a) begin
        if (q_a.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat_a: got addr 0x%0h expected no beat", addr_a);
        end else begin
          e_a = q_a.pop_front();
          chk("beat_a", {22'b0, wf_a, wl_a, addr_a}, {22'b0, e_a.f, e_a.l, e_a.a[39:0]});
          if (beat_a == 0)
            chk("first_beat_a", 64'({wf_a, addr_a}),
                64'({1'b1, 10'd504, 10'd336, 10'd168, 10'd0}));
          if (beat_a == 4)  chk("tap_0_4_a", 64'(addr_a[9:0]), 64'd4);
          if (beat_a == 5)  chk("tap_1_0_a", 64'(addr_a[9:0]), 64'd28);
          if (beat_a == 24) chk("tap_4_4_a", 64'({wl_a, addr_a[9:0]}), 64'({1'b1, 10'd116}));
          if (beat_a == 25) chk("second_window_a", 64'({wf_a, addr_a[9:0]}), 64'({1'b1, 10'd1}));
          if (beat_a == 600) chk("row1_window0_a", 64'(addr_a[9:0]), 64'd28);
          if (beat_a == 3599)
            chk("last_beat_a", 64'({wl_a, addr_a[39:30]}), 64'({1'b1, 10'd783}));
          beat_a++;
          if (q_a.size() == 0) exp_done_a = 1'b1;
        end
      end
      held_a   = valid_a && !ready_a;
      held_val = {22'b0, wf_a, wl_a, addr_a};
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_done_b = 1'b0;
    end else begin
      if (exp_done_b) begin
        chk("done_after_last_b", 64'({done_b, valid_b}), 64'd2);
        exp_done_b = 1'b0;
      end
      if (valid_b && ready_b) begin
        if (q_b.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat_b: got addr 0x%0h expected no beat", addr_b);
        end else begin
          e_b = q_b.pop_front();
          chk("beat_b", {46'b0, wf_b, wl_b, addr_b}, {46'b0, e_b.f, e_b.l, e_b.a[15:0]});
          if (beat_b == 0)  chk("first_beat_b", 64'({wf_b, addr_b}), 64'({1'b1, 8'd72, 8'd0}));
          if (beat_b == 9)  chk("second_window_b", 64'(addr_b[7:0]), 64'd3);
          if (beat_b == 71) chk("last_beat_b", 64'({wl_b, addr_b[15:8]}), 64'({1'b1, 8'd143}));
          beat_b++;
          if (q_b.size() == 0) exp_done_b = 1'b1;
        end
      end
    end
  end

  // Called just after a clock edge; returns just after the edge that sampled start.
  task automatic start_pass_a(input bit from_done);
    beat_a = 0;
    push_pass(28, 5, 1, 4, 6, 24, 10, 1'b0);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    if (from_done) chk("restart_from_done_a", 64'({busy_a, done_a, valid_a, wf_a}), 64'hB);
    else           chk("start_latency_a", 64'({busy_a, done_a, valid_a, wf_a}), 64'hB);
  endtask

  task automatic wait_done_a(input bit rnd, input int unsigned bound, input int unsigned poke);
    int unsigned cyc;
    cyc = 0;
    while (!done_a && cyc < bound) begin
      @(posedge clk); #1;
      cyc++;
      if (rnd) ready_a = 1'($urandom_range(0, 1));
      start_a = (poke != 0) && (cyc == poke);
    end
    start_a = 1'b0;
    ready_a = 1'b1;
    chk("done_reached_a", 64'({busy_a, done_a}), 64'd1);
    chk("beat_count_a", 64'(beat_a), 64'd3600);
    chk("queue_empty_a", 64'(q_a.size()), 64'd0);
  endtask

  initial begin
    int unsigned cyc;
    n_checks = 0; n_fail = 0; beat_a = 0; beat_b = 0;
    held_a = 1'b0; exp_done_a = 1'b0; exp_done_b = 1'b0; held_val = '0;
    reset_n = 1'b0; start_a = 1'b1; ready_a = 1'b1; start_b = 1'b0; ready_b = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("reset_flags_a", 64'({valid_a, busy_a, done_a, wf_a, wl_a}), 64'd0);
    chk("reset_addr_a", 64'(addr_a), 64'd0);
    chk("reset_flags_b", 64'({valid_b, busy_b, done_b, wf_b, wl_b, addr_b}), 64'd0);
    start_a = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Full pass with ready high and a start pulse that lands mid-run.
    start_pass_a(1'b0);
    wait_done_a(1'b0, 20000, 500);

    // Restart straight from DONE with ready toggling at random.
    start_pass_a(1'b1);
    wait_done_a(1'b1, 30000, 0);

    // Abandon a pass with reset at beat 1000, then restart from the base.
    start_pass_a(1'b0);
    cyc = 0;
    while (beat_a < 1000 && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("reached_beat_1000_a", 64'(beat_a), 64'd1000);
    reset_n = 1'b0;
    q_a.delete();
    @(posedge clk); #1;
    chk("midpass_reset_flags_a", 64'({valid_a, busy_a, done_a, wf_a, wl_a}), 64'd0);
    chk("midpass_reset_addr_a", 64'(addr_a), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset_a", 64'({valid_a, busy_a, done_a}), 64'd0);
    start_pass_a(1'b0);
    wait_done_a(1'b0, 20000, 0);

    // Second geometry.
    beat_b = 0;
    push_pass(12, 3, 3, 2, 2, 4, 8, 1'b1);
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    chk("start_latency_b", 64'({busy_b, done_b, valid_b, wf_b}), 64'hB);
    cyc = 0;
    while (!done_b && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_reached_b", 64'({busy_b, done_b}), 64'd1);
    chk("beat_count_b", 64'(beat_b), 64'd72);
    chk("queue_empty_b", 64'(q_b.size()), 64'd0);
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit with %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
